// File: rtl/video_timing_ctrl.sv
// Raster timing controller: col/row/frame counters, DE and frame/line strobes.
// Optional config validation when VIDEO_TIMING_CFG_CHECK_EN is defined.
module video_timing_ctrl #(
   parameter int CNT_W          = 11,
   parameter int DEF_COL_TOTAL  = 10,
   parameter int DEF_COL_ACTIVE = 8,
   parameter int DEF_ROW_TOTAL  = 8,
   parameter int DEF_ROW_ACTIVE = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [CNT_W-1:0] cfg_col_total_i,
   input  logic [CNT_W-1:0] cfg_col_active_i,
   input  logic [CNT_W-1:0] cfg_row_total_i,
   input  logic [CNT_W-1:0] cfg_row_active_i,
   output logic             cfg_err_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] col_o,
   output logic [CNT_W-1:0] row_o,
   output logic [CNT_W-1:0] frm_o,
   output logic             de_o,
   output logic             sof_o,
   output logic             eol_o,
   output logic             eof_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] col_q;
   logic [CNT_W-1:0] col_d;
   logic [CNT_W-1:0] row_q;
   logic [CNT_W-1:0] row_d;
   logic [CNT_W-1:0] frm_q;

   logic [CNT_W-1:0] act_ct_q;
   logic [CNT_W-1:0] act_ca_q;
   logic [CNT_W-1:0] act_rt_q;
   logic [CNT_W-1:0] act_ra_q;
   logic [CNT_W-1:0] pnd_ct_q;
   logic [CNT_W-1:0] pnd_ca_q;
   logic [CNT_W-1:0] pnd_rt_q;
   logic [CNT_W-1:0] pnd_ra_q;
   logic             pnd_q;
   logic             err_q;

   logic             run;
   logic             eol;
   logic             eof;
   logic             xfer;
   logic             cfg_ok;
   logic             apply;

   assign run   = (state_q != IDLE);
   assign eol   = run && (col_q == act_ct_q - CNT_W'(1));
   assign eof   = eol && (row_q == act_rt_q - CNT_W'(1));
   assign xfer  = cfg_valid_i && !pnd_q;
   // Pending timing lands only between frames so the raster never tears.
   assign apply = pnd_q && (!run || eof);

`ifdef VIDEO_TIMING_CFG_CHECK_EN
   assign cfg_ok = (cfg_col_total_i >= CNT_W'(2))
                && (cfg_col_active_i != '0)
                && (cfg_col_active_i <= cfg_col_total_i)
                && (cfg_row_total_i >= CNT_W'(2))
                && (cfg_row_active_i != '0)
                && (cfg_row_active_i <= cfg_row_total_i);
`else
   assign cfg_ok = 1'b1;
`endif

   assign cfg_ready_o = !pnd_q;
   assign cfg_err_o   = err_q;
   assign busy_o      = run;
   assign col_o       = col_q;
   assign row_o       = row_q;
   assign frm_o       = frm_q;
   assign de_o        = run && (col_q < act_ca_q) && (row_q < act_ra_q);
   assign sof_o       = run && (col_q == '0) && (row_q == '0);
   assign eol_o       = eol;
   assign eof_o       = eof;

   // Next state and raster counter stepping.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      unique case (state_q)
         IDLE: begin
            col_d = '0;
            row_d = '0;
            if (en_i) state_d = RUN;
         end
         RUN, DRAIN: begin
            if (eol) begin
               col_d = '0;
               row_d = eof ? '0 : row_q + CNT_W'(1);
            end else begin
               col_d = col_q + CNT_W'(1);
            end
            if (eof) state_d = en_i ? RUN : IDLE;
            else     state_d = en_i ? RUN : DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and frame count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         frm_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if (eof) frm_q <= frm_q + CNT_W'(1);
      end
   end

   // Config capture, rejection pulse and frame-boundary apply.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_ct_q <= CNT_W'(DEF_COL_TOTAL);
         act_ca_q <= CNT_W'(DEF_COL_ACTIVE);
         act_rt_q <= CNT_W'(DEF_ROW_TOTAL);
         act_ra_q <= CNT_W'(DEF_ROW_ACTIVE);
         pnd_ct_q <= '0;
         pnd_ca_q <= '0;
         pnd_rt_q <= '0;
         pnd_ra_q <= '0;
         pnd_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= xfer && !cfg_ok;
         if (apply) begin
            act_ct_q <= pnd_ct_q;
            act_ca_q <= pnd_ca_q;
            act_rt_q <= pnd_rt_q;
            act_ra_q <= pnd_ra_q;
            pnd_q    <= 1'b0;
         end else if (xfer && cfg_ok) begin
            pnd_ct_q <= cfg_col_total_i;
            pnd_ca_q <= cfg_col_active_i;
            pnd_rt_q <= cfg_row_total_i;
            pnd_ra_q <= cfg_row_active_i;
            pnd_q    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl.
// Queued per-cycle expectations checked on negedge.
module tb_video_timing_ctrl;

  localparam int W = 11;

  localparam int S_COL  = 0;
  localparam int S_ROW  = 1;
  localparam int S_FRM  = 2;
  localparam int S_DE   = 3;
  localparam int S_SOF  = 4;
  localparam int S_EOL  = 5;
  localparam int S_EOF  = 6;
  localparam int S_BUSY = 7;
  localparam int S_RDY  = 8;
  localparam int S_ERR  = 9;
  localparam int S_FLEN = 10;
  localparam int S_DCNT = 11;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_ct;
  logic [W-1:0] cfg_ca;
  logic [W-1:0] cfg_rt;
  logic [W-1:0] cfg_ra;
  logic         cfg_err;
  logic         busy;
  logic [W-1:0] col;
  logic [W-1:0] row;
  logic [W-1:0] frm;
  logic         de;
  logic         sof;
  logic         eol;
  logic         eof;

  video_timing_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .cfg_valid_i      (cfg_valid),
    .cfg_ready_o      (cfg_ready),
    .cfg_col_total_i  (cfg_ct),
    .cfg_col_active_i (cfg_ca),
    .cfg_row_total_i  (cfg_rt),
    .cfg_row_active_i (cfg_ra),
    .cfg_err_o        (cfg_err),
    .busy_o           (busy),
    .col_o            (col),
    .row_o            (row),
    .frm_o            (frm),
    .de_o             (de),
    .sof_o            (sof),
    .eol_o            (eol),
    .eof_o            (eof)
  );

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string nm;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   de_acc = 0;
  int   last_eof = 0;
  int   flen = -1;
  int   dcnt = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int obs(int s);
    case (s)
      S_COL:  return int'(col);
      S_ROW:  return int'(row);
      S_FRM:  return int'(frm);
      S_DE:   return int'(de);
      S_SOF:  return int'(sof);
      S_EOL:  return int'(eol);
      S_EOF:  return int'(eof);
      S_BUSY: return int'(busy);
      S_RDY:  return int'(cfg_ready);
      S_ERR:  return int'(cfg_err);
      S_FLEN: return flen;
      S_DCNT: return dcnt;
      default: return -99;
    endcase
  endfunction

  always @(negedge clk) begin
    if (de === 1'b1) de_acc = de_acc + 1;
    if (eof === 1'b1) begin
      flen     = cyc - last_eof;
      dcnt     = de_acc;
      de_acc   = 0;
      last_eof = cyc;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_cmp = n_cmp + 1;
        if (obs(sb[i].sel) !== sb[i].exp) begin
          n_bad = n_bad + 1;
          $display("FAIL %s @cyc %0d: got %0d expected %0d",
                   sb[i].nm, cyc, obs(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(int c, int s, int e, string n);
    sb.push_back('{c, s, e, n});
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(int ct, int ca, int rt, int ra);
    cfg_valid = 1'b1;
    cfg_ct    = W'(ct);
    cfg_ca    = W'(ca);
    cfg_rt    = W'(rt);
    cfg_ra    = W'(ra);
  endtask

  int t0;
  int f2;
  int g0;
  int b;
  int c0;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ct    = '0;
    cfg_ca    = '0;
    cfg_rt    = '0;
    cfg_ra    = '0;

    wait_until(3);
    n_cmp = n_cmp + 1;
    if (cfg_ready !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL rst_rdy_direct: got %b", cfg_ready);
    end
    chk(3, S_COL, 0, "rst_col");
    chk(3, S_ROW, 0, "rst_row");
    chk(3, S_FRM, 0, "rst_frm");
    chk(3, S_DE, 0, "rst_de");
    chk(3, S_SOF, 0, "rst_sof");
    chk(3, S_EOL, 0, "rst_eol");
    chk(3, S_EOF, 0, "rst_eof");
    chk(3, S_BUSY, 0, "rst_busy");
    chk(3, S_RDY, 1, "rst_ready");
    chk(3, S_ERR, 0, "rst_err");
    rst_n = 1'b1;

    wait_until(5);
    en = 1'b1;
    t0 = cyc + 1;
    chk(t0 - 1, S_BUSY, 0, "idle_busy");
    chk(t0, S_SOF, 1, "t1_sof");
    chk(t0, S_BUSY, 1, "t1_busy");
    chk(t0, S_DE, 1, "t1_de0");
    chk(t0 + 7, S_DE, 1, "t1_de7");
    chk(t0 + 8, S_DE, 0, "t1_de8");
    chk(t0 + 9, S_EOL, 1, "t1_eol");
    chk(t0 + 9, S_EOF, 0, "t1_eof_row0");
    chk(t0 + 61, S_DE, 0, "t1_de_row6");
    chk(t0 + 79, S_EOF, 1, "t1_eof");
    chk(t0 + 79, S_FRM, 0, "t1_frm0");
    chk(t0 + 80, S_SOF, 1, "t1_sof2");
    chk(t0 + 80, S_FRM, 1, "t1_frm1");
    chk(t0 + 159, S_FLEN, 80, "t1_flen");
    chk(t0 + 159, S_DCNT, 48, "t1_decnt");
    chk(t0 + 160, S_FRM, 2, "t1_frm2");

    f2 = t0 + 160;
`ifdef VIDEO_TIMING_CFG_CHECK_EN
    wait_until(f2 + 10);
    offer(8, 9, 8, 6);
    chk(f2 + 10, S_RDY, 1, "inv_rdy0");
    wait_until(f2 + 11);
    cfg_valid = 1'b0;
    chk(f2 + 11, S_ERR, 1, "inv_err");
    chk(f2 + 11, S_RDY, 1, "inv_rdy1");
    chk(f2 + 12, S_ERR, 0, "inv_err_off");
`endif
    wait_until(f2 + 34);
    en = 1'b0;
    chk(f2 + 34, S_COL, 4, "t2_col");
    chk(f2 + 34, S_ROW, 3, "t2_row");
    chk(f2 + 35, S_BUSY, 1, "t2_drain_busy");
    chk(f2 + 35, S_COL, 5, "t2_drain_col");
    chk(f2 + 79, S_EOF, 1, "t2_eof");
    chk(f2 + 79, S_COL, 9, "t2_eof_col");
    chk(f2 + 79, S_ROW, 7, "t2_eof_row");
    chk(f2 + 79, S_FLEN, 80, "t2_flen");
    chk(f2 + 80, S_BUSY, 0, "t2_idle");
    chk(f2 + 80, S_COL, 0, "t2_idle_col");
    chk(f2 + 80, S_ROW, 0, "t2_idle_row");
    chk(f2 + 80, S_DE, 0, "t2_idle_de");
    chk(f2 + 80, S_FRM, 3, "t2_frm");

    wait_until(f2 + 82);
    en = 1'b1;
    g0 = cyc + 1;
    chk(f2 + 82, S_FRM, 3, "t2_frm_hold");
    chk(g0, S_SOF, 1, "t3_sof");
    wait_until(g0 + 20);
    offer(12, 10, 6, 4);
    chk(g0 + 20, S_RDY, 1, "t3_rdy_pre");
    wait_until(g0 + 21);
    cfg_valid = 1'b0;
    chk(g0 + 21, S_RDY, 0, "t3_rdy_low");
    chk(g0 + 79, S_EOF, 1, "t3_old_eof");
    chk(g0 + 79, S_RDY, 0, "t3_rdy_eof");
    chk(g0 + 80, S_RDY, 1, "t3_rdy_back");
    chk(g0 + 80, S_SOF, 1, "t3_sof2");
    chk(g0 + 80, S_FRM, 4, "t3_frm4");
    chk(g0 + 89, S_EOL, 0, "t3_no_eol9");
    chk(g0 + 89, S_DE, 1, "t3_de9");
    chk(g0 + 90, S_DE, 0, "t3_de10");
    chk(g0 + 91, S_EOL, 1, "t3_eol11");
    chk(g0 + 151, S_EOF, 1, "t3_eof");
    chk(g0 + 151, S_FLEN, 72, "t3_flen");
    chk(g0 + 151, S_DCNT, 40, "t3_decnt");
    wait_until(g0 + 152);
    en = 1'b0;
    chk(g0 + 152, S_FRM, 5, "t3_frm5");
    chk(g0 + 152, S_BUSY, 1, "t3_busy");
    chk(g0 + 223, S_FLEN, 72, "t3_flen2");
    chk(g0 + 224, S_BUSY, 0, "t3_idle");
    chk(g0 + 224, S_FRM, 6, "t3_frm6");

    wait_until(g0 + 226);
    b = cyc;
    offer(4, 2, 3, 1);
    chk(b, S_RDY, 1, "t5_rdy0");
    wait_until(b + 1);
    cfg_valid = 1'b0;
    en = 1'b1;
    chk(b + 1, S_RDY, 0, "t5_rdy_low");
    chk(b + 1, S_BUSY, 0, "t5_still_idle");
    chk(b + 2, S_BUSY, 1, "t5_busy");
    chk(b + 2, S_SOF, 1, "t5_sof");
    chk(b + 2, S_DE, 1, "t5_de0");
    chk(b + 2, S_RDY, 1, "t5_rdy_back");
    chk(b + 3, S_DE, 1, "t5_de1");
    chk(b + 4, S_DE, 0, "t5_de2");
    chk(b + 5, S_EOL, 1, "t5_eol");
    chk(b + 5, S_COL, 3, "t5_eol_col");
    chk(b + 6, S_DE, 0, "t5_de_row1");
    chk(b + 6, S_ROW, 1, "t5_row1");
    chk(b + 13, S_EOF, 1, "t5_eof");
    chk(b + 13, S_ROW, 2, "t5_eof_row");
    chk(b + 14, S_FRM, 7, "t5_frm7");
    chk(b + 25, S_FLEN, 12, "t5_flen");
    chk(b + 25, S_DCNT, 2, "t5_decnt");

    wait_until(b + 14);
    offer(12, 10, 6, 4);
    wait_until(b + 15);
    cfg_valid = 1'b0;
    chk(b + 15, S_RDY, 0, "t6_rdy_low");
    chk(b + 26, S_RDY, 1, "t6_rdy_back");
    wait_until(b + 30);
    offer(4, 2, 3, 1);
    wait_until(b + 31);
    cfg_valid = 1'b0;
    chk(b + 31, S_RDY, 0, "t6_pend");
    chk(b + 54, S_COL, 4, "t6_col");
    chk(b + 54, S_ROW, 2, "t6_row");
    chk(b + 54, S_DE, 1, "t6_de");

    wait_until(b + 55);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if (de !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL ar_de_direct: got %b", de);
    end
    n_cmp = n_cmp + 1;
    if (busy !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL ar_busy_direct: got %b", busy);
    end
    chk(b + 55, S_COL, 0, "ar_col");
    chk(b + 55, S_ROW, 0, "ar_row");
    chk(b + 55, S_FRM, 0, "ar_frm");
    chk(b + 55, S_DE, 0, "ar_de");
    chk(b + 55, S_SOF, 0, "ar_sof");
    chk(b + 55, S_EOL, 0, "ar_eol");
    chk(b + 55, S_BUSY, 0, "ar_busy");
    chk(b + 55, S_RDY, 1, "ar_rdy");
    wait_until(b + 57);
    rst_n = 1'b1;
    wait_until(b + 58);
    en = 1'b1;
    c0 = cyc + 1;
    chk(c0, S_SOF, 1, "pr_sof");
    chk(c0 + 7, S_DE, 1, "pr_de7");
    chk(c0 + 8, S_DE, 0, "pr_de8");
    chk(c0 + 9, S_EOL, 1, "pr_eol");
    chk(c0 + 79, S_EOF, 1, "pr_eof");
    chk(c0 + 79, S_ROW, 7, "pr_eof_row");
    chk(c0 + 80, S_FRM, 1, "pr_frm");
    chk(c0 + 80, S_RDY, 1, "pr_rdy");
    chk(c0 + 89, S_EOL, 1, "pr_eol2");
    wait_until(c0 + 85);
    en = 1'b0;
    chk(c0 + 159, S_FLEN, 80, "pr_flen");
    chk(c0 + 160, S_BUSY, 0, "pr_idle");

    wait_until(c0 + 165);
    @(negedge clk);
    foreach (sb[i]) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: never observed, expected %0d at cyc %0d",
               sb[i].nm, sb[i].exp, sb[i].cyc);
    end
    if (n_bad == 0) $display("PASS");
    else            $display("FAILED");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
